// File: rtl/gbt_frameclk_pkg.sv
// ---------------------------------------------------------------------------
// gbt_frameclk_pkg
// Shared types for the GBT RX frame-clock enable generator.
//   state_e : lock-supervisor state; the encoding is also what state_o shows
//             (UNLOCKED=0, STABILIZING=1, LOCKED=2).
// ---------------------------------------------------------------------------
package gbt_frameclk_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_UNLOCKED    = 2'd0,
        ST_STABILIZING = 2'd1,
        ST_LOCKED      = 2'd2
    } state_e;

endpackage

// File: rtl/gbt_frameclk_en_gen_if.sv
// ---------------------------------------------------------------------------
// gbt_frameclk_en_gen_if
// Control/status bundle of the frame-clock enable generator.
//   ch_enable_i     : per-channel strobe gate
//   phase_i         : channel i phase in bits [i*PHASE_W +: PHASE_W]
//   phase_load_i    : one-cycle pulse, captures phase_i
//   lost_lock_clr_i : clears the sticky lost-lock flag
//   frame_en_o      : one-cycle frame strobes
//   locked_o        : high while the supervisor is LOCKED
//   lost_lock_o     : sticky, lock dropped while LOCKED
//   state_o         : supervisor state
// master = the controlling side, slave = the generator.
// ---------------------------------------------------------------------------
interface gbt_frameclk_en_gen_if
    import gbt_frameclk_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 2
) ();

    logic [NUM_CH-1:0]         ch_enable_i;
    logic [NUM_CH*PHASE_W-1:0] phase_i;
    logic                      phase_load_i;
    logic                      lost_lock_clr_i;
    logic [NUM_CH-1:0]         frame_en_o;
    logic                      locked_o;
    logic                      lost_lock_o;
    state_e                    state_o;

    modport master (
        output ch_enable_i, phase_i, phase_load_i, lost_lock_clr_i,
        input  frame_en_o, locked_o, lost_lock_o, state_o
    );

    modport slave (
        input  ch_enable_i, phase_i, phase_load_i, lost_lock_clr_i,
        output frame_en_o, locked_o, lost_lock_o, state_o
    );

endinterface

// File: rtl/gbt_bit_sync.sv
// ---------------------------------------------------------------------------
// gbt_bit_sync
// Single-bit synchroniser: STAGES flops in series, cleared by reset.
//   clk : destination clock
//   rst : synchronous active-high reset
//   d   : asynchronous input
//   q   : synchronised output (STAGES cycles of latency)
// ---------------------------------------------------------------------------
module gbt_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: non-blocking assignments make every stage take its neighbour's
    // old value, which is exactly the shift the synchroniser relies on.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gbt_frameclk_en_gen.sv
// ---------------------------------------------------------------------------
// gbt_frameclk_en_gen
// Frame-clock enable generator and PLL lock supervisor. Synchronises the PLL
// lock indication, requires it to be stable for LOCK_STABLE_CYCLES before
// declaring LOCKED, then emits NUM_CH one-cycle strobes at refclk/DIV_RATIO,
// each at a programmable phase inside the frame.
//   refclk       : sole clock (PLL reference)
//   rst          : synchronous active-high reset
//   pll_locked_i : asynchronous PLL lock indication
//   bus          : control/status bundle (slave side)
// ---------------------------------------------------------------------------
module gbt_frameclk_en_gen
    import gbt_frameclk_pkg::*;
#(
    parameter int DIV_RATIO          = 3,
    parameter int NUM_CH             = 4,
    parameter int PHASE_W            = $clog2(DIV_RATIO),
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked_i,
    gbt_frameclk_en_gen_if.slave bus
);

    localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int EXT_W = PHASE_W + 1;

    localparam logic [CNT_W-1:0]   STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] DIV_LAST  = PHASE_W'(DIV_RATIO - 1);
    localparam logic [EXT_W-1:0]   DIV_EXT   = EXT_W'(DIV_RATIO);

    logic               lock_s;
    state_e             state;
    logic [CNT_W-1:0]   stab_cnt;
    logic               locked_q;
    logic               lost_lock_q;
    logic [PHASE_W-1:0] divider;
    logic               frame_live;
    logic               wrap;
    logic               copy_en;
    logic [NUM_CH-1:0]  frame_en;

    gbt_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked_i),
        .q   (lock_s)
    );

    // Lock supervisor. locked_q tracks the LOCKED state as its own flop so
    // locked_o is a clean register output.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= ST_UNLOCKED;
            stab_cnt    <= '0;
            locked_q    <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            case (state)
                ST_UNLOCKED: begin
                    if (lock_s) begin
                        state    <= ST_STABILIZING;
                        stab_cnt <= '0;
                    end
                end
                ST_STABILIZING: begin
                    if (!lock_s) begin
                        state <= ST_UNLOCKED;
                    end else if (stab_cnt == STAB_LAST) begin
                        state    <= ST_LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!lock_s) begin
                        state    <= ST_UNLOCKED;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_UNLOCKED;
                    locked_q <= 1'b0;
                end
            endcase

            // Set has priority so a loss coinciding with a clear is not missed.
            if ((state == ST_LOCKED) && !lock_s) begin
                lost_lock_q <= 1'b1;
            end else if (bus.lost_lock_clr_i) begin
                lost_lock_q <= 1'b0;
            end
        end
    end

    // LOCKED and staying LOCKED next cycle. Gating on lock_s lets the strobes
    // stop in the same cycle that locked_o falls.
    assign frame_live = (state == ST_LOCKED) && lock_s;
    assign wrap       = (divider == DIV_LAST);

    // Shadow phases move to the active set only at a frame boundary so a
    // phase change can never drop or duplicate a strobe; outside LOCKED there
    // is no frame to protect and the copy is immediate.
    assign copy_en = (state != ST_LOCKED) || wrap;

    always_ff @(posedge refclk) begin
        if (rst) begin
            divider <= '0;
        end else if (frame_live) begin
            divider <= wrap ? '0 : divider + PHASE_W'(1);
        end else begin
            divider <= '0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PHASE_W-1:0] raw_phase;
        logic [PHASE_W-1:0] sat_phase;
        logic [PHASE_W-1:0] shadow_phase;
        logic [PHASE_W-1:0] active_phase;
        logic               strobe_q;

        assign raw_phase = bus.phase_i[g*PHASE_W +: PHASE_W];
        // Out-of-range phases clamp to the last slot of the frame.
        assign sat_phase = ({1'b0, raw_phase} >= DIV_EXT) ? DIV_LAST : raw_phase;

        always_ff @(posedge refclk) begin
            if (rst) begin
                shadow_phase <= '0;
                active_phase <= '0;
                strobe_q     <= 1'b0;
            end else begin
                if (bus.phase_load_i) begin
                    shadow_phase <= sat_phase;
                end
                if (copy_en) begin
                    active_phase <= shadow_phase;
                end
                strobe_q <= frame_live && (divider == active_phase) && bus.ch_enable_i[g];
            end
        end

        assign frame_en[g] = strobe_q;
    end

    assign bus.frame_en_o  = frame_en;
    assign bus.locked_o    = locked_q;
    assign bus.lost_lock_o = lost_lock_q;
    assign bus.state_o     = state;

endmodule

// File: tb/tb_gbt_frameclk_en_gen.sv
// ---------------------------------------------------------------------------
// tb_gbt_frameclk_en_gen
// Scripted lock-up / glitch / lock-loss / phase-change / reset sequence
// followed by randomized stimulus. Expected outputs come from a cycle-history
// model: lock is a window test over the synchronised lock history, the
// divider is the distance from the start of the locked run, and each frame
// uses the phase held in the shadow register just before the frame began.
// ---------------------------------------------------------------------------
module tb_gbt_frameclk_en_gen;
    import gbt_frameclk_pkg::*;

    localparam int DIV   = 3;
    localparam int NCH   = 2;
    localparam int PW    = 2;
    localparam int PHW   = NCH * PW;
    localparam int SYNC  = 2;
    localparam int LSC   = 16;
    localparam int NCYC  = 3000;
    localparam int MAXC  = NCYC + 8;

    logic refclk = 1'b0;
    logic rst;
    logic pll_locked_i;

    gbt_frameclk_en_gen_if #(.NUM_CH(NCH), .PHASE_W(PW)) bus ();

    gbt_frameclk_en_gen #(
        .DIV_RATIO          (DIV),
        .NUM_CH             (NCH),
        .PHASE_W            (PW),
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LSC)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked_i (pll_locked_i),
        .bus          (bus)
    );

    always #5 refclk = ~refclk;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;

    // Per-cycle input history and model results.
    bit pll_h [MAXC];
    bit rst_h [MAXC];
    bit load_h[MAXC];
    bit clr_h [MAXC];
    bit ls_h  [MAXC];
    bit eff_h [MAXC];
    bit locked_m[MAXC];
    bit lost_m  [MAXC];
    int en_h [MAXC];
    int ph_h [MAXC];
    int div_m[MAXC];
    int shadow_m[MAXC][NCH];
    int phase_m [MAXC][NCH];
    int run_start = 0;

    bit drv_pll, drv_rst, drv_load, drv_clr;
    int drv_en, drv_ph;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    endtask

    task automatic model_and_check();
        int n;
        bit ls, lk;
        int st, lost, fe, f;
        n = cyc;

        // Synchronised lock: input from SYNC cycles ago, unless a reset hit the chain since.
        ls = 1'b0;
        if (n >= SYNC) begin
            ls = pll_h[n-SYNC];
            for (int k = n - SYNC; k < n; k++) if (rst_h[k]) ls = 1'b0;
        end
        ls_h[n] = ls;

        // LOCKED iff the last LSC+1 cycles all saw lock without reset.
        lk = (n >= LSC + 1);
        if (lk) for (int k = n - 1 - LSC; k < n; k++) if (!eff_h[k]) lk = 1'b0;
        locked_m[n] = lk;

        st = lk ? 2 : (eff_h[n-1] ? 1 : 0);

        if (rst_h[n-1])                      lost = 0;
        else if (locked_m[n-1] && !lk)       lost = 1;
        else if (clr_h[n-1])                 lost = 0;
        else                                 lost = int'(lost_m[n-1]);
        lost_m[n] = (lost != 0);

        for (int ch = 0; ch < NCH; ch++) begin
            if (rst_h[n-1]) shadow_m[n][ch] = 0;
            else if (load_h[n-1]) begin
                f = (ph_h[n-1] >> (ch * PW)) & ((1 << PW) - 1);
                shadow_m[n][ch] = (f >= DIV) ? DIV - 1 : f;
            end else shadow_m[n][ch] = shadow_m[n-1][ch];
        end

        if (lk) begin
            if (!locked_m[n-1]) run_start = n;
            div_m[n] = (n - run_start) % DIV;
        end else div_m[n] = 0;

        // A frame's phase is whatever the shadow held in the cycle before it started.
        for (int ch = 0; ch < NCH; ch++)
            phase_m[n][ch] = (lk && div_m[n] != 0) ? phase_m[n-1][ch] : shadow_m[n-1][ch];

        fe = 0;
        for (int ch = 0; ch < NCH; ch++)
            if (locked_m[n-1] && lk && div_m[n-1] == phase_m[n-1][ch] && ((en_h[n-1] >> ch) & 1) != 0)
                fe |= (1 << ch);

        check("state",     int'(bus.state_o),     st);
        check("locked",    int'(bus.locked_o),    int'(lk));
        check("lost_lock", int'(bus.lost_lock_o), lost);
        check("frame_en",  int'(bus.frame_en_o),  fe);
    endtask

    task automatic step();
        pll_h[cyc]  = drv_pll;
        rst_h[cyc]  = drv_rst;
        load_h[cyc] = drv_load;
        clr_h[cyc]  = drv_clr;
        en_h[cyc]   = drv_en;
        ph_h[cyc]   = drv_ph;
        eff_h[cyc]  = ls_h[cyc] && !drv_rst;

        rst                 = drv_rst;
        pll_locked_i        = drv_pll;
        bus.ch_enable_i     = NCH'(drv_en);
        bus.phase_i         = PHW'(drv_ph);
        bus.phase_load_i    = drv_load;
        bus.lost_lock_clr_i = drv_clr;

        @(posedge refclk);
        #1;
        cyc++;
        model_and_check();
    endtask

    int first_lock = -1, first_fe0 = -1, first_fe1 = -1;
    int unlock_cyc = -1, relock_cyc = -1;

    initial begin
        drv_pll = 1'b0; drv_rst = 1'b1; drv_load = 1'b0; drv_clr = 1'b0;
        drv_en  = 3;    drv_ph  = 0;

        while (cyc < NCYC) begin
            if (cyc < 300) begin
                drv_rst  = (cyc <= 2) || (cyc == 240);
                drv_load = (cyc == 4) || (cyc == 60) || (cyc == 80);
                if (cyc == 4)  drv_ph = 8;   // ch0=0, ch1=2
                if (cyc == 60) drv_ph = 10;  // ch0=2 mid-frame
                if (cyc == 80) drv_ph = 7;   // ch0=3 saturates, ch1=1
                if (cyc == 10 || cyc == 135 || cyc == 143 || cyc == 205) drv_pll = 1'b1;
                if (cyc == 120 || cyc == 140 || cyc == 185) drv_pll = 1'b0;
                if (cyc == 100) drv_en = 1;
                if (cyc == 120) drv_en = 3;
                drv_clr = (cyc == 130) || (cyc >= 180 && cyc < 200);
            end else begin
                if ($urandom % 150 == 0) drv_pll = !drv_pll;
                drv_rst  = ($urandom % 700 == 0);
                drv_load = ($urandom % 8 == 0);
                drv_ph   = int'($urandom % 16);
                if ($urandom % 60 == 0) drv_en = int'($urandom % 4);
                drv_clr  = ($urandom % 25 == 0);
            end

            step();

            if (cyc <= 60) begin
                if (bus.locked_o && first_lock < 0)    first_lock = cyc;
                if (bus.frame_en_o[0] && first_fe0 < 0) first_fe0 = cyc;
                if (bus.frame_en_o[1] && first_fe1 < 0) first_fe1 = cyc;
            end
            if (cyc > 100 && cyc < 130 && !bus.locked_o && unlock_cyc < 0) unlock_cyc = cyc;
            if (cyc > 125 && cyc < 175 && bus.locked_o && relock_cyc < 0)  relock_cyc = cyc;

            if (cyc == 61) begin
                check("lockup_cycle",   first_lock, 29);
                check("ch0_first_strb", first_fe0,  30);
                check("ch1_first_strb", first_fe1,  32);
            end
            if (cyc == 175) begin
                check("unlock_cycle",      unlock_cyc, 123);
                check("relock_after_glch", relock_cyc, 162);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
